sat_updown_counter: RTL and testbench
=====================================

Name: sat_updown_counter

Overview:
- Parametrised successor to the single-bit latching counter.
- Up/down counter with configurable width and bounds.
- Runtime-selectable bound behaviour: latch (saturate) at the bound, or wrap around.
- Also provides synchronous clear, parallel load, a terminal-count pulse and a sticky overflow flag.
- Used as the generic timeout/occurrence counter for control FSMs.

Parameters:
- WIDTH, 8: counter width in bits.
- MIN_VAL, 0: lower bound and reset/clear value.
- MAX_VAL, 255: upper bound. Requires MIN_VAL < MAX_VAL <= 2**WIDTH-1; elaboration error otherwise.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-high.
- clr  input  1  synchronous clear to MIN_VAL; also clears ovf.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value for load.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- wrap  input  1  mode: 0 = latch at bound, 1 = wrap to opposite bound.
- count  output  WIDTH  current value (registered).
- at_max  output  1  count == MAX_VAL (combinational from count).
- at_min  output  1  count == MIN_VAL (combinational from count).
- tc  output  1  terminal-count pulse (registered, one cycle).
- ovf  output  1  sticky overflow/underflow flag (registered).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: count=MIN_VAL, tc=0, ovf=0.
- The same values also hold from time zero (initial) for simulation.
- Priority per edge: rst > clr > load > en. Lower-priority inputs are ignored when a higher one is active.
- clr: count<=MIN_VAL, ovf<=0, tc<=0.
- load: count<=clamp(load_val). Values above MAX_VAL load MAX_VAL; values below MIN_VAL load MIN_VAL. tc<=0; ovf unchanged.
- en=0 (no clr/load): count holds, tc<=0.
- en=1, up=1, count<MAX_VAL: count<=count+1.
  - tc<=1 iff the new count==MAX_VAL.
- en=1, up=1, count==MAX_VAL, wrap=0: count holds (latched); tc<=0; ovf<=1.
- en=1, up=1, count==MAX_VAL, wrap=1: count<=MIN_VAL; tc<=1; ovf<=1.
- Decrement is symmetric: MIN_VAL is the bound.
  - Step reaching MIN_VAL gives tc<=1.
  - Underflow attempt at MIN_VAL sets ovf; it holds (wrap=0) or goes to MAX_VAL with tc<=1 (wrap=1).
- Latency: count, tc and ovf change one edge after the qualifying inputs. at_max/at_min follow count combinationally (zero added latency).
- tc is never asserted two consecutive cycles while latched at a bound. Holding at the bound does not re-pulse.
- Arithmetic: compare against bounds before stepping. No intermediate value outside [MIN_VAL, MAX_VAL] is ever registered. MAX_VAL = 2**WIDTH-1 must not rely on natural overflow.
- Wrap/up may change any cycle; they are sampled on the same edge as en.
- Reset mid-count overrides every other input on that edge.

Decomposition:
- Shared package: direction constants (DIR_DOWN=0, DIR_UP=1) and mode constants (MODE_LATCH=0, MODE_WRAP=1) for callers.
- Package also holds a clamp function(value, min, max) reused by load paths elsewhere.
- No sub-module: a single always block for state plus continuous assigns for at_max/at_min.

Test Plan (WIDTH=4, MIN_VAL=2, MAX_VAL=9 unless noted):
- Reset then en=1, up=1, wrap=0 for 10 cycles -> count 2,3,...,9 then holds 9; tc high exactly one cycle (count becomes 9); ovf=1 from the first edge after reaching 9; at_max=1.
- From count=9, wrap=1, en=1, up=1 -> count=2, tc=1 one cycle, ovf=1. Then down from 2 -> count=9, tc=1.
- load=1, load_val=15 -> count=9. load_val=0 -> count=2. load and en together -> load wins.
- clr with ovf=1 and count=7 -> count=2, ovf=0, tc=0. rst, clr and load together -> rst result (count=2).
- en=1, up=0, wrap=0 from count=3 -> 2 (tc=1), then holds 2 (tc=0, ovf=1, at_min=1).
- WIDTH=4, MIN_VAL=0, MAX_VAL=15, wrap=1, up=1 from 15 -> count=0, tc=1, no X/overflow artefacts. rst asserted mid-sequence -> count=0 next edge.

Source files
------------

// File: rtl/sat_updown_counter_pkg.sv
// rtl/sat_updown_counter_pkg.sv - shared constants and clamp helper for the saturating up/down counter
package sat_updown_counter_pkg;

    localparam logic DIR_DOWN   = 1'b0;
    localparam logic DIR_UP     = 1'b1;
    localparam logic MODE_LATCH = 1'b0;
    localparam logic MODE_WRAP  = 1'b1;

    function automatic int unsigned clamp_val(
        input int unsigned value,
        input int unsigned lo,
        input int unsigned hi
    );
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// rtl/sat_updown_counter.sv - up/down counter with latch-or-wrap bounds, load, terminal-count pulse and sticky overflow
module sat_updown_counter
    import sat_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MIN_VAL = 0,
    parameter int unsigned MAX_VAL = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    input  logic             wrap,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MIN_L = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_VAL);

    generate
        if (!(MIN_VAL < MAX_VAL && 64'(MAX_VAL) <= ((64'd1 << WIDTH) - 64'd1))) begin : g_bad_bounds
            $error("sat_updown_counter: bounds must satisfy MIN_VAL < MAX_VAL <= 2**WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] count_q = MIN_L;
    logic             tc_q    = 1'b0;
    logic             ovf_q   = 1'b0;

    // Bounds are tested before stepping, so the +1/-1 never leaves [MIN_VAL, MAX_VAL].
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_q <= MIN_L;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (load) begin
            count_q <= WIDTH'(clamp_val(32'(load_val), MIN_VAL, MAX_VAL));
            tc_q    <= 1'b0;
        end else if (!en) begin
            tc_q <= 1'b0;
        end else if (up == DIR_UP) begin
            if (count_q == MAX_L) begin
                ovf_q <= 1'b1;
                if (wrap == MODE_WRAP) begin
                    count_q <= MIN_L;
                    tc_q    <= 1'b1;
                end else begin
                    tc_q <= 1'b0;
                end
            end else begin
                count_q <= count_q + 1'b1;
                tc_q    <= (count_q == MAX_L - 1'b1);
            end
        end else begin
            if (count_q == MIN_L) begin
                ovf_q <= 1'b1;
                if (wrap == MODE_WRAP) begin
                    count_q <= MAX_L;
                    tc_q    <= 1'b1;
                end else begin
                    tc_q <= 1'b0;
                end
            end else begin
                count_q <= count_q - 1'b1;
                tc_q    <= (count_q == MIN_L + 1'b1);
            end
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign ovf    = ovf_q;
    assign at_max = (count_q == MAX_L);
    assign at_min = (count_q == MIN_L);

endmodule

// File: tb/tb_sat_updown_counter.sv
// tb/tb_sat_updown_counter.sv - directed vector bench for sat_updown_counter
module tb_sat_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance a: WIDTH=4, MIN_VAL=2, MAX_VAL=9
    logic       rst_a = 1'b0, clr_a = 1'b0, load_a = 1'b0, en_a = 1'b0, up_a = 1'b0, wrap_a = 1'b0;
    logic [3:0] load_val_a = 4'd0;
    logic [3:0] count_a;
    logic       at_max_a, at_min_a, tc_a, ovf_a;

    // Instance b: WIDTH=4, MIN_VAL=0, MAX_VAL=15
    logic       rst_b = 1'b0, clr_b = 1'b0, load_b = 1'b0, en_b = 1'b0, up_b = 1'b0, wrap_b = 1'b0;
    logic [3:0] load_val_b = 4'd0;
    logic [3:0] count_b;
    logic       at_max_b, at_min_b, tc_b, ovf_b;

    sat_updown_counter #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(9)) dut_a (
        .clk(clk), .rst(rst_a), .clr(clr_a), .load(load_a), .load_val(load_val_a),
        .en(en_a), .up(up_a), .wrap(wrap_a), .count(count_a),
        .at_max(at_max_a), .at_min(at_min_a), .tc(tc_a), .ovf(ovf_a)
    );

    sat_updown_counter #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(15)) dut_b (
        .clk(clk), .rst(rst_b), .clr(clr_b), .load(load_b), .load_val(load_val_b),
        .en(en_b), .up(up_b), .wrap(wrap_b), .count(count_b),
        .at_max(at_max_b), .at_min(at_min_b), .tc(tc_b), .ovf(ovf_b)
    );

    typedef struct {
        logic       rst, clr, load;
        logic [3:0] load_val;
        logic       en, up, wrap;
        logic [3:0] exp_count;
        logic       exp_tc, exp_ovf, exp_max, exp_min;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(
        input logic r, input logic c, input logic l, input logic [3:0] lv,
        input logic e, input logic u, input logic w,
        input logic [3:0] ec, input logic et, input logic eo, input logic emx, input logic emn
    );
        vec_t v;
        v.rst = r; v.clr = c; v.load = l; v.load_val = lv;
        v.en = e; v.up = u; v.wrap = w;
        v.exp_count = ec; v.exp_tc = et; v.exp_ovf = eo; v.exp_max = emx; v.exp_min = emn;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic step_b(input logic r, input logic l, input logic [3:0] lv, input logic e,
                          input logic u, input logic w);
        rst_b = r; load_b = l; load_val_b = lv; en_b = e; up_b = u; wrap_b = w; clr_b = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("init_count_a", -1, count_a, 4'd2);
        chk("init_tc_a", -1, {3'b0, tc_a}, 4'd0);
        chk("init_ovf_a", -1, {3'b0, ovf_a}, 4'd0);

        //   rst clr ld  lv    en up wr  count tc ovf max min
        vecs.push_back(mk(1, 0, 0, 4'd0, 0, 0, 0, 4'd2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd4, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd6, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd7, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd8, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd9, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd9, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd9, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 1, 4'd2, 1, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 0, 1, 4'd9, 1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 4'd15, 1, 1, 1, 4'd9, 0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 4'd0, 0, 0, 0, 4'd2, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 4'd7, 0, 0, 0, 4'd7, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 4'd5, 1, 1, 0, 4'd2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 4'd3, 0, 0, 0, 4'd3, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 0, 0, 4'd2, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 0, 0, 4'd2, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 0, 0, 4'd2, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 1, 4'd7, 0, 0, 0, 4'd7, 0, 1, 0, 0));
        vecs.push_back(mk(1, 1, 1, 4'd9, 1, 1, 0, 4'd2, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 4'd5, 0, 0, 0, 4'd5, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd6, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 0, 4'd6, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 4'd8, 0, 0, 0, 4'd8, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 1, 1, 0, 4'd9, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 4'd0, 0, 1, 0, 4'd9, 0, 0, 1, 0));

        foreach (vecs[i]) begin
            rst_a = vecs[i].rst; clr_a = vecs[i].clr; load_a = vecs[i].load;
            load_val_a = vecs[i].load_val; en_a = vecs[i].en; up_a = vecs[i].up; wrap_a = vecs[i].wrap;
            @(posedge clk);
            #1;
            chk("count_a", i, count_a, vecs[i].exp_count);
            chk("tc_a", i, {3'b0, tc_a}, {3'b0, vecs[i].exp_tc});
            chk("ovf_a", i, {3'b0, ovf_a}, {3'b0, vecs[i].exp_ovf});
            chk("at_max_a", i, {3'b0, at_max_a}, {3'b0, vecs[i].exp_max});
            chk("at_min_a", i, {3'b0, at_min_a}, {3'b0, vecs[i].exp_min});
        end

        // Full-range instance: wrap at 2**WIDTH-1 and reset mid-count.
        step_b(1, 0, 4'd0, 0, 0, 0);
        chk("b_reset_count", 0, count_b, 4'd0);
        step_b(0, 1, 4'd14, 0, 0, 0);
        chk("b_load_count", 1, count_b, 4'd14);
        step_b(0, 0, 4'd0, 1, 1, 1);
        chk("b_count_15", 2, count_b, 4'd15);
        chk("b_tc_15", 2, {3'b0, tc_b}, 4'd1);
        chk("b_at_max", 2, {3'b0, at_max_b}, 4'd1);
        chk("b_ovf_pre", 2, {3'b0, ovf_b}, 4'd0);
        step_b(0, 0, 4'd0, 1, 1, 1);
        chk("b_wrap_count", 3, count_b, 4'd0);
        chk("b_wrap_tc", 3, {3'b0, tc_b}, 4'd1);
        chk("b_wrap_ovf", 3, {3'b0, ovf_b}, 4'd1);
        chk("b_wrap_at_min", 3, {3'b0, at_min_b}, 4'd1);
        step_b(0, 0, 4'd0, 1, 1, 1);
        chk("b_count_1", 4, count_b, 4'd1);
        chk("b_tc_1", 4, {3'b0, tc_b}, 4'd0);
        step_b(0, 0, 4'd0, 1, 1, 1);
        chk("b_count_2", 5, count_b, 4'd2);
        step_b(1, 1, 4'd9, 1, 1, 1);
        chk("b_midrst_count", 6, count_b, 4'd0);
        chk("b_midrst_ovf", 6, {3'b0, ovf_b}, 4'd0);
        chk("b_midrst_tc", 6, {3'b0, tc_b}, 4'd0);
        step_b(0, 0, 4'd0, 1, 0, 0);
        chk("b_under_count", 7, count_b, 4'd0);
        chk("b_under_ovf", 7, {3'b0, ovf_b}, 4'd1);
        chk("b_under_tc", 7, {3'b0, tc_b}, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
